// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: logical / arithmetic / rotate / ones-fill in either direction.
// One amount bit is resolved per stage, largest sub-shift first; the pipeline holds as a whole under backpressure.
module barrel_shift_pipe #(
    parameter int WIDTH = 8,
    parameter int TAGW  = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_tag
);

    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;
    localparam logic [1:0] MODE_ONES  = 2'b11;

    logic stall;

    // Shift by a fixed distance; vacated bits come from the rotated-out bits or the fill bit.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input int               sh,
        input logic             dir,
        input logic             rot,
        input logic             fill
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] body;
        logic [WIDTH-1:0] ins;
        ones = '1;
        if (dir) begin
            body = d << sh;
            if (rot)
                ins = d >> (WIDTH - sh);
            else
                ins = fill ? ~(ones << sh) : '0;
        end else begin
            body = d >> sh;
            if (rot)
                ins = d << (WIDTH - sh);
            else
                ins = fill ? ~(ones >> sh) : '0;
        end
        return body | ins;
    endfunction

    for (genvar gi = 0; gi < SHW; gi++) begin : stage
        localparam int AW = SHW - gi;          // amount bits still pending at this stage's input
        localparam int SH = 1 << (AW - 1);

        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic [AW-1:0]    src_amt;
        logic             src_dir;
        logic [1:0]       src_mode;
        logic             src_fill;
        logic [TAGW-1:0]  src_tag;
        logic [WIDTH-1:0] data_next;

        logic             valid_reg;
        logic [WIDTH-1:0] data_reg;
        logic [TAGW-1:0]  tag_reg;

        if (gi == 0) begin : g_src
            // Fill bit is fixed at entry so arithmetic mode keeps the original operand MSB.
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign src_amt   = in_amt;
            assign src_dir   = in_dir;
            assign src_mode  = in_mode;
            assign src_tag   = in_tag;
            assign src_fill  = (in_mode == MODE_ONES) ||
                               ((in_mode == MODE_ARITH) && !in_dir && in_data[WIDTH-1]);
        end else begin : g_src
            assign src_valid = stage[gi-1].valid_reg;
            assign src_data  = stage[gi-1].data_reg;
            assign src_amt   = stage[gi-1].g_ctl.amt_reg;
            assign src_dir   = stage[gi-1].g_ctl.dir_reg;
            assign src_mode  = stage[gi-1].g_ctl.mode_reg;
            assign src_fill  = stage[gi-1].g_ctl.fill_reg;
            assign src_tag   = stage[gi-1].tag_reg;
        end

        assign data_next = src_amt[AW-1]
                         ? shift_step(src_data, SH, src_dir, src_mode == MODE_ROT, src_fill)
                         : src_data;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
                tag_reg   <= '0;
            end else if (!stall) begin
                valid_reg <= src_valid;
                data_reg  <= data_next;
                tag_reg   <= src_tag;
            end
        end

        // The final stage only presents a result, so it carries no control state.
        if (gi < SHW - 1) begin : g_ctl
            logic [AW-2:0] amt_reg;
            logic          dir_reg;
            logic [1:0]    mode_reg;
            logic          fill_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    amt_reg  <= '0;
                    dir_reg  <= 1'b0;
                    mode_reg <= 2'b00;
                    fill_reg <= 1'b0;
                end else if (!stall) begin
                    amt_reg  <= src_amt[AW-2:0];
                    dir_reg  <= src_dir;
                    mode_reg <= src_mode;
                    fill_reg <= src_fill;
                end
            end
        end
    end

    assign out_valid = stage[SHW-1].valid_reg;
    assign out_data  = stage[SHW-1].data_reg;
    assign out_tag   = stage[SHW-1].tag_reg;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall | ~rst_n;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: directed latency/literal cases plus randomized
// traffic scored against a bit-by-bit reference model.
module tb_barrel_shift_pipe;

    localparam int W   = 8;
    localparam int TW  = 4;
    localparam int SHW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SHW-1:0] in_amt;
    logic          in_dir;
    logic [1:0]    in_mode;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;

    int n_checks = 0;
    int n_pass   = 0;
    int out_cnt  = 0;

    logic [TW+W-1:0] exp_q[$];

    barrel_shift_pipe #(.WIDTH(W), .TAGW(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each result bit i comes from source bit i+amt (right) or i-amt (left); out-of-range sources use the mode rule.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int a,
                                           input logic dir, input logic [1:0] mode);
        logic [W-1:0] r;
        int src;
        r = '0;
        for (int i = 0; i < W; i++) begin
            src = dir ? i - a : i + a;
            if (src >= 0 && src < W)
                r[i] = d[src];
            else begin
                case (mode)
                    2'b10:   r[i] = d[(src + W) % W];
                    2'b11:   r[i] = 1'b1;
                    2'b01:   r[i] = dir ? 1'b0 : d[W-1];
                    default: r[i] = 1'b0;
                endcase
            end
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        else
            n_pass++;
    endtask

    // Scoreboard: all sampling at the falling edge, describing the transfer at the next rising edge.
    logic          hold_prev = 1'b0;
    logic [W-1:0]  prev_data;
    logic [TW-1:0] prev_tag;

    always @(negedge clk) begin
        logic [TW+W-1:0] e;
        check("in_ready", in_ready, (!(out_valid && !out_ready)) || !rst_n);
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_data);
                check("hold_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                $display("out: tag=%0h data=%02h", out_tag, out_data);
                if (exp_q.size() == 0)
                    check("spurious_out", out_valid, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[W-1:0]);
                    check("out_tag", out_tag, e[TW+W-1:W]);
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back({in_tag, model(in_data, int'(in_amt), in_dir, in_mode)});
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_tag  = out_tag;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one op and return just after the edge that accepted it.
    task automatic send(input logic [W-1:0] d, input int a, input logic dir,
                        input logic [1:0] mode, input logic [TW-1:0] tag);
        int w;
        in_data  = d;
        in_amt   = SHW'(a);
        in_dir   = dir;
        in_mode  = mode;
        in_tag   = tag;
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("send_timeout", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    // Single op on an idle pipe: pin the model to a literal and check exact latency and result.
    task automatic timed_op(input string nm, input logic [W-1:0] d, input int a, input logic dir,
                            input logic [1:0] mode, input logic [TW-1:0] tag, input logic [W-1:0] exp);
        check({nm, "_model"}, model(d, a, dir, mode), exp);
        out_ready = 1'b1;
        send(d, a, dir, mode, tag);
        for (int k = 0; k < SHW - 1; k++) begin
            @(negedge clk);
            check({nm, "_early"}, out_valid, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        check({nm, "_valid"}, out_valid, 1'b1);
        check({nm, "_data"}, out_data, exp);
        check({nm, "_tag"}, out_tag, tag);
        tick();
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        in_mode   = 2'b00;
        in_tag    = '0;
        out_ready = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_tag", out_tag, 4'h0);
        tick();
        rst_n = 1'b1;
        tick();

        timed_op("lsr", 8'h3F, 2, 1'b0, 2'b00, 4'h1, 8'h0F);
        timed_op("asr_neg", 8'h80, 3, 1'b0, 2'b01, 4'h2, 8'hF0);
        timed_op("asr_pos", 8'h70, 3, 1'b0, 2'b01, 4'h3, 8'h0E);
        timed_op("ones_l", 8'h01, 2, 1'b1, 2'b11, 4'h4, 8'h07);
        timed_op("lsl", 8'h07, 1, 1'b1, 2'b00, 4'h5, 8'h0E);
        timed_op("rol", 8'h81, 1, 1'b1, 2'b10, 4'h6, 8'h03);
        timed_op("asl", 8'hC1, 2, 1'b1, 2'b01, 4'h7, 8'h04);
        for (int m = 0; m < 4; m++)
            timed_op("amt0", 8'hA5, 0, m[0], m[1:0], 4'(m), 8'hA5);

        // Back-to-back rotate right at full throughput.
        check("ror1_model", model(8'h60, 4, 1'b0, 2'b10), 8'h06);
        check("ror2_model", model(8'h43, 1, 1'b0, 2'b10), 8'hA1);
        check("ror3_model", model(8'h0C, 6, 1'b0, 2'b10), 8'h30);
        out_ready = 1'b1;
        send(8'h60, 4, 1'b0, 2'b10, 4'h8);
        send(8'h43, 1, 1'b0, 2'b10, 4'h9);
        send(8'h0C, 6, 1'b0, 2'b10, 4'hA);
        @(negedge clk);
        check("b2b_0", {out_valid, out_data}, {1'b1, 8'h06});
        @(negedge clk);
        check("b2b_1", {out_valid, out_data}, {1'b1, 8'hA1});
        @(negedge clk);
        check("b2b_2", {out_valid, out_data}, {1'b1, 8'h30});
        repeat (3) tick();

        // Backpressure: fill, hold for five cycles, then release.
        base = out_cnt;
        out_ready = 1'b0;
        send(8'h96, 1, 1'b0, 2'b00, 4'hB);
        send(8'h96, 2, 1'b1, 2'b10, 4'hC);
        send(8'h96, 3, 1'b0, 2'b01, 4'hD);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        repeat (6) tick();
        check("bp_delivered", out_cnt - base, 3);
        check("bp_drained", exp_q.size(), 0);

        // Reset with two operations in flight.
        send(8'h11, 1, 1'b1, 2'b00, 4'hE);
        send(8'h22, 1, 1'b1, 2'b00, 4'hF);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        base = out_cnt;
        @(negedge clk);
        check("mrst_out_valid", out_valid, 1'b0);
        repeat (6) tick();
        check("mrst_discarded", out_cnt - base, 0);
        timed_op("post_rst", 8'h5A, 4, 1'b0, 2'b11, 4'h3, 8'hF5);

        // Randomized traffic with random backpressure and occasional reset.
        for (int it = 0; it < 1500; it++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = W'($urandom);
            in_amt    = SHW'($urandom);
            in_dir    = 1'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = TW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            tick();
        end
        in_valid  = 1'b0;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) tick();
        check("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/barrel_shift_pipe.md
BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width; power of two, 4 to 64.
REQ-002 Parameter TAGW, default 4, width of a user tag carried alongside the data.
REQ-003 Derived constant SHW = log2(WIDTH), default 3; this is the shift-amount width and the number of pipeline stages.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  input operation present.
REQ-007 in_ready  output  1  block can accept an operation this cycle.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_amt  input  SHW  shift amount, 0 to WIDTH-1.
REQ-010 in_dir  input  1  direction: 0 = right, 1 = left.
REQ-011 in_mode  input  2  00 logical (zero fill), 01 arithmetic, 10 rotate, 11 ones fill.
REQ-012 in_tag  input  TAGW  user tag, passed through unchanged.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_data  output  WIDTH  shifted result.
REQ-016 out_tag  output  TAGW  tag of the operation whose result is on out_data.

Function
REQ-017 The block SHALL have SHW register stages; stage k (k=1..SHW) conditionally shifts by 2^(SHW-k) when amount bit SHW-k is set, so the largest sub-shift comes first.
REQ-018 Each stage SHALL register: valid, partial data, remaining amount bits, dir, mode and tag.
REQ-019 Stage 1 SHALL take its inputs directly from the in_* ports.
REQ-020 An operation SHALL transfer in on a rising edge where in_valid=1 and in_ready=1.
REQ-021 stall SHALL equal out_valid AND NOT out_ready.
REQ-022 in_ready SHALL equal NOT stall; the pipeline does not collapse bubbles.
REQ-023 When stall=0, every stage SHALL load from its predecessor on each edge, and stage 1 valid SHALL load in_valid.
REQ-024 When stall=1, every stage register SHALL hold its value.
REQ-025 Latency: with no stall, an operation accepted at edge N SHALL appear with out_valid=1 immediately after edge N+SHW-1 (SHW edges including the accepting edge).
REQ-026 Throughput SHALL be one operation per cycle when out_ready is held at 1.
REQ-027 out_data, out_tag and out_valid SHALL be taken directly from the final stage registers, with no combinational path from in_*.
REQ-028 Logical mode SHALL fill vacated bits with 0 in either direction.
REQ-029 Arithmetic mode, right shift, SHALL fill vacated bits with the operand MSB captured at input.
REQ-030 Arithmetic mode, left shift, SHALL behave identically to logical left.
REQ-031 Rotate mode SHALL re-insert the bits shifted out at the opposite end.
REQ-032 Ones-fill mode SHALL fill vacated bits with 1 in either direction.
REQ-033 in_amt=0 SHALL pass in_data unchanged in every mode.
REQ-034 out_valid and out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-035 Each accepted operation SHALL appear on the output exactly once, in order.
REQ-036 The block SHALL be bit-accurate for every WIDTH in range; no WIDTH=8-specific logic.

Reset
REQ-037 When rst_n=0 at an edge, all stage valid bits SHALL clear to 0, giving out_valid=0 and in_ready=1 after that edge.
REQ-038 The same reset edge SHALL clear out_data and out_tag to 0.
REQ-039 Reset SHALL override stall and in_valid; operations in flight at reset are discarded, not delivered.
REQ-040 in_ready SHALL be 1 during reset.

Verification (WIDTH=8, TAGW=4; format: data, amt, dir, mode, tag)
REQ-041 Logical right: 0x3F, 2, R, 00, tag 1 -> out 0x0F, tag 1, 3 edges after acceptance.
REQ-042 Rotate right, back-to-back: 0x60/4 then 0x43/1 then 0x0C/6, out_ready=1 -> 0x06, 0xA1, 0x30 on consecutive cycles.
REQ-043 Arithmetic and ones-fill:
- arithmetic right 0x80/3 -> 0xF0
- arithmetic right 0x70/3 -> 0x0E
- ones-fill left 0x01/2 -> 0x07
REQ-044 Left shifts:
- logical left 0x07/1 -> 0x0E
- rotate left 0x81/1 -> 0x03
- amt=0 with each mode on 0xA5 -> 0xA5
REQ-045 Backpressure: fill the pipe with 3 operations, hold out_ready=0 for 5 cycles -> in_ready=0 and out_data held; release -> all 3 results delivered in order, none lost or duplicated.
REQ-046 Mid-operation reset: 2 operations in flight, rst_n=0 for one edge -> out_valid=0 after that edge and neither result ever appears; the next accepted operation completes with normal latency.
